// File: rtl/darkuart_txfifo.sv
`default_nettype none
// ============================================================================
// darkuart_txfifo: byte FIFO feeding the dark UART through single-cycle byte writes.
// Revision: 1.0
// ============================================================================
module darkuart_txfifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  input  logic [7:0]            s_data_i,
  output logic                  s_ready_o,
  input  logic                  flush_i,
  input  logic                  ovfl_clr_i,
  output logic                  ovfl_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  u_wr_o,
  output logic [3:0]            u_be_o,
  output logic [31:0]           u_datao_o,
  input  logic [31:0]           u_datai_i
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            xbyte_q, xbyte_d;
  logic                  ovfl_q, ovfl_d;
  logic [7:0]            mem_q [DEPTH];

  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  busy;
  logic                  unused_datai;

  assign busy         = u_datai_i[0];
  assign unused_datai = ^u_datai_i[31:1];

  // Pointers carry a wrap bit, so the modulo difference is the exact occupancy.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == LEVEL_FULL);
  assign s_ready_o = ~full;
  assign level_o   = level;
  assign ovfl_o    = ovfl_q;
  assign empty_o   = (level == '0) & (state_q == IDLE) & ~busy;

  // A push coinciding with a flush is accepted on the handshake but discarded.
  assign push = s_valid_i & ~full & ~flush_i;
  assign pop  = (state_q == SEND) & ~flush_i & (level != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  assign ovfl_d = (s_valid_i & full) | (ovfl_q & ~ovfl_clr_i);

  always_comb begin
    state_d   = state_q;
    xbyte_d   = xbyte_q;
    u_wr_o    = 1'b0;
    u_be_o    = 4'b0000;
    u_datao_o = 32'd0;
    case (state_q)
      IDLE: begin
        // Launch blocked during flush so the popped slot can never outrun the flushed pointers.
        if ((level != '0) && !busy && !flush_i) begin
          state_d = SEND;
          xbyte_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
      end
      SEND: begin
        u_wr_o    = 1'b1;
        u_be_o    = 4'b0010;
        u_datao_o = {16'd0, xbyte_q, 8'd0};
        state_d   = GUARD;
      end
      GUARD: begin
        // One dead cycle lets the UART busy flag rise before it is sampled again.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      xbyte_q  <= 8'd0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      xbyte_q  <= xbyte_d;
      ovfl_q   <= ovfl_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_darkuart_txfifo.sv
`default_nettype none
// ============================================================================
// tb_darkuart_txfifo: directed stimulus with a queue scoreboard on UART writes.
// Revision: 1.0
// ============================================================================
module tb_darkuart_txfifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready;
  logic        flush = 1'b0;
  logic        ovfl_clr = 1'b0;
  logic        ovfl;
  logic [4:0]  level;
  logic        empty;
  logic        u_wr;
  logic [3:0]  u_be;
  logic [31:0] u_datao;
  logic [31:0] u_datai = 32'd0;

  darkuart_txfifo #(.DEPTH_LOG2(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .s_ready_o  (s_ready),
    .flush_i    (flush),
    .ovfl_clr_i (ovfl_clr),
    .ovfl_o     (ovfl),
    .level_o    (level),
    .empty_o    (empty),
    .u_wr_o     (u_wr),
    .u_be_o     (u_be),
    .u_datao_o  (u_datao),
    .u_datai_i  (u_datai)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          last_wr = -100;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (u_wr) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got data=%h be=%b, none expected", u_datao, u_be);
      end else begin
        mon_exp = exp_q.pop_front();
        if (u_datao !== mon_exp || u_be !== 4'b0010) begin
          errors++;
          $display("FAIL write_data: got data=%h be=%b, expected data=%h be=0010",
                   u_datao, u_be, mon_exp);
        end
      end
      checks++;
      if (cyc - last_wr < 3) begin
        errors++;
        $display("FAIL write_spacing: got %0d cycles, expected >= 3", cyc - last_wr);
      end
      last_wr = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bit found;

    // Reset values, then quiet after release
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", s_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_wr", u_wr, 0);
    chk("rst_be", u_be, 0);
    chk("rst_datao", u_datao, 0);
    chk("rst_empty", empty, 1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("idle_ready", s_ready, 1);
    chk("idle_level", level, 0);
    chk("idle_ovfl", ovfl, 0);
    chk("idle_wr", u_wr, 0);
    chk("idle_empty", empty, 1);

    // Two bytes, UART idle
    tick();
    s_valid = 1'b1; s_data = 8'h41; exp_q.push_back(32'h0000_4100);
    tick();
    s_data = 8'h42; exp_q.push_back(32'h0000_4200);
    @(negedge clk);
    chk("no_early_write", u_wr, 0);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("first_write_latency", u_wr, 1);
    repeat (8) tick();
    @(negedge clk);
    chk("drain_level", level, 0);
    chk("drain_empty", empty, 1);

    // Busy holds the byte; upper DATAI bits are don't-care
    tick();
    w0 = wr_count;
    u_datai = 32'hFFFF_FFFF;
    s_valid = 1'b1; s_data = 8'h55; exp_q.push_back(32'h0000_5500);
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("busy_level", level, 1);
    chk("busy_empty", empty, 0);
    chk("busy_blocks_write", wr_count, w0);
    tick();
    u_datai = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("release_same_cycle", u_wr, 0);
    tick();
    @(negedge clk);
    chk("release_latency", u_wr, 1);
    repeat (4) tick();

    // Fill to full, overflow, clear priority
    u_datai = 32'd1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'h80 + 8'(i);
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("full_level", level, 16);
    chk("full_ready", s_ready, 0);
    chk("full_ovfl", ovfl, 0);
    tick();
    s_valid = 1'b1; s_data = 8'hEE;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("ovfl_set", ovfl, 1);
    chk("ovfl_level", level, 16);
    tick();
    s_valid = 1'b1; ovfl_clr = 1'b1;
    tick();
    s_valid = 1'b0; ovfl_clr = 1'b0;
    @(negedge clk);
    chk("ovfl_set_wins", ovfl, 1);
    tick();
    ovfl_clr = 1'b1;
    tick();
    ovfl_clr = 1'b0;
    @(negedge clk);
    chk("ovfl_clr", ovfl, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_full_level", level, 0);
    chk("flush_full_ready", s_ready, 1);
    chk("empty_needs_uart_idle", empty, 0);

    // Flush during SEND: in-flight byte still written, rest discarded
    tick();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'h61 + 8'(i);
      tick();
    end
    s_valid = 1'b0;
    exp_q.push_back(32'h0000_6100);
    @(negedge clk);
    chk("queued4_level", level, 4);
    w0 = wr_count;
    tick();
    u_datai = 32'd0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_send_wr", u_wr, 1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_send_level", level, 0);
    repeat (10) tick();
    @(negedge clk);
    chk("flush_single_write", wr_count, w0 + 1);
    chk("flush_final_empty", empty, 1);

    // Reset in the middle of SEND
    tick();
    w0 = wr_count;
    s_valid = 1'b1; s_data = 8'h71; exp_q.push_back(32'h0000_7100);
    tick();
    s_data = 8'h72;
    tick();
    s_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (u_wr) found = 1'b1;
    end
    chk("mid_send_reached", found, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr", u_wr, 0);
    chk("async_rst_be", u_be, 0);
    chk("async_rst_datao", u_datao, 0);
    chk("async_rst_level", level, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("post_rst_no_stale", wr_count, w0 + 1);
    chk("post_rst_level", level, 0);
    chk("post_rst_empty", empty, 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
